// File: rtl/uart_reg_bridge.sv
// UART command sequencer: parses 0x57/0x52 commands from received bytes, drives an
// 8-bit register bus and returns one reply byte (ACK, read data or NAK) to the UART.
module uart_reg_bridge #(
  parameter int unsigned BYTE_TIMEOUT = 2500000,
  parameter int unsigned RD_TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_active,
  output logic [7:0] bus_addr,
  output logic       bus_wr_en,
  output logic [7:0] bus_wr_data,
  output logic       bus_rd_en,
  input  logic [7:0] bus_rd_data,
  input  logic       bus_rd_valid,
  output logic [7:0] drop_count
);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int RT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_RD,
    S_TX_START,
    S_TX_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      bus_addr_q, bus_addr_d;
  logic [7:0]      bus_wr_data_q, bus_wr_data_d;
  logic            bus_wr_en_q, bus_wr_en_d;
  logic            bus_rd_en_q, bus_rd_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic            tx_en_dly_q, tx_en_dly_d;
  logic [7:0]      drop_count_q, drop_count_d;
  logic [BT_W-1:0] byte_tmr_q, byte_tmr_d;
  logic [RT_W-1:0] rd_tmr_q, rd_tmr_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    bus_wr_en_d   = 1'b0;
    bus_rd_en_d   = 1'b0;
    tx_data_d     = tx_data_q;
    tx_en_d       = 1'b0;
    tx_en_dly_d   = tx_en_q;
    drop_count_d  = drop_count_q;
    byte_tmr_d    = '0;
    rd_tmr_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_en) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            is_wr_d = (rx_data == OP_WR);
            state_d = S_ADDR;
          end else begin
            tx_data_d = NAK;
            state_d   = S_TX_START;
          end
        end
      end
      S_ADDR: begin
        if (rx_en) begin
          bus_addr_d = rx_data;
          if (is_wr_q) begin
            state_d = S_DATA;
          end else begin
            bus_rd_en_d = 1'b1;
            state_d     = S_BUS_RD;
          end
        end else if (byte_tmr_q == BT_LAST) begin
          state_d = S_IDLE;
        end else begin
          byte_tmr_d = byte_tmr_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_en) begin
          bus_wr_data_d = rx_data;
          bus_wr_en_d   = 1'b1;
          tx_data_d     = ACK;
          state_d       = S_TX_START;
        end else if (byte_tmr_q == BT_LAST) begin
          state_d = S_IDLE;
        end else begin
          byte_tmr_d = byte_tmr_q + 1'b1;
        end
      end
      // Read completion strobes tx_en straight away so the reply follows
      // bus_rd_valid by one cycle; TX_START then sees the pulse already issued.
      S_BUS_RD: begin
        rd_tmr_d = rd_tmr_q + 1'b1;
        if (bus_rd_valid) begin
          tx_data_d = bus_rd_data;
          tx_en_d   = 1'b1;
          state_d   = S_TX_START;
        end else if (rd_tmr_q == RT_LAST) begin
          tx_data_d = NAK;
          tx_en_d   = 1'b1;
          state_d   = S_TX_START;
        end
      end
      S_TX_START: begin
        tx_en_d = !tx_en_q;
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!tx_en_q && !tx_en_dly_q && !tx_active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_en && (state_q == S_BUS_RD || state_q == S_TX_START || state_q == S_TX_WAIT))
      drop_count_d = sat_inc(drop_count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      is_wr_q       <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      bus_wr_en_q   <= 1'b0;
      bus_rd_en_q   <= 1'b0;
      tx_data_q     <= '0;
      tx_en_q       <= 1'b0;
      tx_en_dly_q   <= 1'b0;
      drop_count_q  <= '0;
      byte_tmr_q    <= '0;
      rd_tmr_q      <= '0;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      bus_wr_en_q   <= bus_wr_en_d;
      bus_rd_en_q   <= bus_rd_en_d;
      tx_data_q     <= tx_data_d;
      tx_en_q       <= tx_en_d;
      tx_en_dly_q   <= tx_en_dly_d;
      drop_count_q  <= drop_count_d;
      byte_tmr_q    <= byte_tmr_d;
      rd_tmr_q      <= rd_tmr_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_en       = tx_en_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_en   = bus_wr_en_q;
  assign bus_wr_data = bus_wr_data_q;
  assign bus_rd_en   = bus_rd_en_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomized bench for uart_reg_bridge: a protocol-level model schedules expected
// strobes into a queue and a negedge monitor pops and compares them.
module tb_uart_reg_bridge;

  localparam int BT = 40;
  localparam int RT = 20;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int EV_WR = 1;
  localparam int EV_RD = 2;
  localparam int EV_TX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_active = 1'b0;
  logic [7:0] bus_addr;
  logic       bus_wr_en;
  logic [7:0] bus_wr_data;
  logic       bus_rd_en;
  logic [7:0] bus_rd_data = 8'h00;
  logic       bus_rd_valid = 1'b0;
  logic [7:0] drop_count;

  uart_reg_bridge #(.BYTE_TIMEOUT(BT), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en),
    .tx_data(tx_data), .tx_en(tx_en), .tx_active(tx_active),
    .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_wr_data(bus_wr_data),
    .bus_rd_en(bus_rd_en), .bus_rd_data(bus_rd_data), .bus_rd_valid(bus_rd_valid),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [256];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  task automatic push(input int k, input int c, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (bus_wr_en || bus_rd_en || tx_en) begin
      chk("strobe_count", int'(bus_wr_en) + int'(bus_rd_en) + int'(tx_en), 1);
      kind = bus_wr_en ? EV_WR : (bus_rd_en ? EV_RD : EV_TX);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_kind", kind, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_cycle", cyc, e.cyc);
        if (e.kind == EV_WR) begin
          chk("wr_addr", int'(bus_addr), int'(e.addr));
          chk("wr_data", int'(bus_wr_data), int'(e.data));
        end else if (e.kind == EV_RD) begin
          chk("rd_addr", int'(bus_addr), int'(e.addr));
        end else begin
          chk("tx_data", int'(tx_data), int'(e.data));
        end
      end
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_strobe_cycle", -1, e.cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    bus_rd_valid = 1'b0;
  endtask

  task automatic idle(input int g);
    repeat (g) tick();
  endtask

  task automatic check_drops();
    tick();
    chk("drop_count", int'(drop_count), (exp_drops > 255) ? 255 : exp_drops);
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_bus_wr_en", int'(bus_wr_en), 0);
    chk("rst_bus_rd_en", int'(bus_rd_en), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_bus_addr", int'(bus_addr), 0);
    chk("rst_bus_wr_data", int'(bus_wr_data), 0);
    chk("rst_drop_count", int'(drop_count), 0);
  endtask

  // One full command. rd_d: read-valid delay from the bus_rd_en cycle (-1 = never).
  // The reply's transmitter busy time is tx_l cycles; ndrop bytes are sent while replying.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                         input int gap, input int rd_d, input bit rd_drop,
                         input int tx_l, input int ndrop);
    int n, r, t_tx, c, k;
    logic [7:0] rdval;
    r = -100;
    rdval = 8'h00;
    tick(); rx_en = 1'b1; rx_data = op; n = cyc;
    if (op == 8'h57 || op == 8'h52) begin
      idle(gap);
      tick(); rx_en = 1'b1; rx_data = addr; n = cyc;
      if (op == 8'h57) begin
        idle(gap);
        tick(); rx_en = 1'b1; rx_data = data; n = cyc;
        push(EV_WR, n + 1, addr, data);
        mem[addr] = data;
        t_tx = n + 2;
        push(EV_TX, t_tx, 8'h00, ACK);
      end else begin
        r = n + 1;
        rdval = mem[addr];
        push(EV_RD, r, addr, 8'h00);
        if (rd_d >= 0 && rd_d < RT) begin
          t_tx = r + rd_d + 1;
          push(EV_TX, t_tx, 8'h00, rdval);
        end else begin
          t_tx = r + RT;
          push(EV_TX, t_tx, 8'h00, NAK);
        end
        while (cyc < t_tx - 1) begin
          tick();
          if (rd_d >= 0 && cyc == r + rd_d) begin bus_rd_valid = 1'b1; bus_rd_data = rdval; end
          if (rd_drop && cyc == r) begin rx_en = 1'b1; rx_data = 8'($urandom); exp_drops++; end
        end
      end
    end else begin
      t_tx = n + 2;
      push(EV_TX, t_tx, 8'h00, NAK);
    end
    c = (tx_l + 1 > 2) ? t_tx + tx_l + 1 : t_tx + 2;
    k = 0;
    while (cyc < c) begin
      tick();
      tx_active = (cyc >= t_tx + 1) && (cyc <= t_tx + tx_l);
      if (rd_d >= 0 && cyc == r + rd_d) begin bus_rd_valid = 1'b1; bus_rd_data = 8'($urandom); end
      if (cyc >= t_tx && k < ndrop) begin
        rx_en = 1'b1; rx_data = 8'($urandom); k++; exp_drops++;
      end
    end
  endtask

  // A command abandoned after nb bytes; waits out the inter-byte timeout exactly.
  task automatic run_partial(input logic [7:0] op, input int nb);
    int n;
    tick(); rx_en = 1'b1; rx_data = op; n = cyc;
    if (nb == 2) begin tick(); rx_en = 1'b1; rx_data = 8'($urandom); n = cyc; end
    while (cyc < n + BT) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int t, rd_d;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h22] = 8'h3C;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;

    run_cmd(8'h57, 8'h10, 8'hA5, 0, 0, 1'b0, 3, 0);
    run_cmd(8'h52, 8'h22, 8'h00, 0, 5, 1'b0, 2, 0);
    run_cmd(8'h52, 8'h22, 8'h00, 0, -1, 1'b0, 0, 0);
    run_cmd(8'h52, 8'h22, 8'h00, 0, RT + 1, 1'b0, 1, 0);
    run_cmd(8'h52, 8'h10, 8'h00, 0, RT - 1, 1'b0, 0, 0);
    run_cmd(8'h41, 8'h00, 8'h00, 0, 0, 1'b0, 2, 0);
    run_partial(8'h57, 2);
    run_cmd(8'h52, 8'h10, 8'h00, 0, 2, 1'b0, 0, 0);
    run_partial(8'h52, 1);
    run_cmd(8'h57, 8'h33, 8'h5A, BT - 1, 0, 1'b0, 1, 0);
    check_drops();
    run_cmd(8'h41, 8'h00, 8'h00, 0, 0, 1'b0, 6, 3);
    check_drops();
    run_cmd(8'h52, 8'h33, 8'h00, 0, 3, 1'b1, 0, 0);
    check_drops();

    run_cmd(8'hFF, 8'h00, 8'h00, 0, 0, 1'b0, 300, 300);
    check_drops();

    tick(); rx_en = 1'b1; rx_data = 8'h57;
    tick(); rx_en = 1'b1; rx_data = 8'h10;
    tick(); rst = 1'b1; rx_en = 1'b1; rx_data = 8'hC3;
    tick(); rst = 1'b0;
    check_reset_outputs();
    exp_drops = 0;

    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 9);
      if (t < 4)      op = 8'h57;
      else if (t < 8) op = 8'h52;
      else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
      end
      t = $urandom_range(0, RT + 3);
      rd_d = (t == RT + 3) ? -1 : t;
      run_cmd(op, 8'($urandom_range(0, 15)), 8'($urandom),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, BT - 1) : 0,
              rd_d, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 2));
      if (i % 10 == 9) check_drops();
    end

    idle(5);
    chk("pending_expected", exp_q.size(), 0);
    check_drops();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
